// File: rtl/i2s_audio_rx.sv
// rtl/i2s_audio_rx.sv - I2S receiver: oversampled BCLK/LRCLK/SDATA deserialised into stereo pairs
`timescale 1ns/1ps
module i2s_audio_rx #(
   parameter int SAMPLE_WIDTH   = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clock,
   input  logic                    resetN,
   input  logic                    i2sBclk,
   input  logic                    i2sLrclk,
   input  logic                    i2sData,
   output logic [SAMPLE_WIDTH-1:0] sampleLeft,
   output logic [SAMPLE_WIDTH-1:0] sampleRight,
   output logic                    sampleValid,
   output logic                    locked,
   output logic                    frameError
);
   localparam int CW = $clog2(SAMPLE_WIDTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] W_C    = CW'(SAMPLE_WIDTH);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic {WAIT_SYNC, RUN} state_t;
   state_t state, state_next;

   logic [SYNC_STAGES-1:0]  bclk_sync, lr_sync, data_sync;
   logic                    bclk_hist, lr_prev, channel, left_ok;
   logic [SAMPLE_WIDTH-1:0] shift_reg, shifted;
   logic [CW-1:0]           bit_cnt, cnt_after;
   logic [TW-1:0]           to_cnt;
   logic                    bclk_s, lr_s, d_s, bclk_rise, lr_change, timed_out;

   assign bclk_s    = bclk_sync[SYNC_STAGES-1];
   assign lr_s      = lr_sync[SYNC_STAGES-1];
   assign d_s       = data_sync[SYNC_STAGES-1];
   assign bclk_rise = bclk_s & ~bclk_hist;
   assign lr_change = lr_s != lr_prev;
   assign timed_out = to_cnt == TO_MAX;

   // All three inputs share one stage count so LRCLK/SDATA line up with the detected edge
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         data_sync <= '0;
         bclk_hist <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2sBclk};
         lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2sLrclk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i2sData};
         bclk_hist <= bclk_s;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN)
         to_cnt <= '0;
      else if (bclk_rise)
         to_cnt <= '0;
      else if (!timed_out)
         to_cnt <= to_cnt + TW'(1);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN)
         state <= WAIT_SYNC;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      shifted    = shift_reg;
      cnt_after  = bit_cnt;
      if (bit_cnt < W_C) begin
         shifted   = {shift_reg[SAMPLE_WIDTH-2:0], d_s};
         cnt_after = bit_cnt + CW'(1);
      end
      if (bclk_rise) begin
         if (state == WAIT_SYNC && lr_change)
            state_next = RUN;
      end else if (timed_out) begin
         state_next = WAIT_SYNC;
      end
   end

   // On an LRCLK change the sampled bit still belongs to the slot that just ended
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         lr_prev     <= 1'b0;
         channel     <= 1'b0;
         left_ok     <= 1'b0;
         sampleLeft  <= '0;
         sampleRight <= '0;
         sampleValid <= 1'b0;
         locked      <= 1'b0;
         frameError  <= 1'b0;
      end else begin
         sampleValid <= 1'b0;
         if (bclk_rise)
            lr_prev <= lr_s;
         if (bclk_rise && state == WAIT_SYNC && lr_change) begin
            bit_cnt <= '0;
            channel <= lr_s;
            left_ok <= 1'b0;
         end else if (bclk_rise && state == RUN) begin
            shift_reg <= shifted;
            if (!lr_change) begin
               bit_cnt <= cnt_after;
            end else begin
               bit_cnt <= '0;
               channel <= lr_s;
               if (cnt_after == W_C) begin
                  if (!channel) begin
                     sampleLeft <= shifted;
                     left_ok    <= 1'b1;
                  end else if (left_ok) begin
                     sampleRight <= shifted;
                     sampleValid <= 1'b1;
                     locked      <= 1'b1;
                     left_ok     <= 1'b0;
                  end
               end else begin
                  frameError <= 1'b1;
                  left_ok    <= 1'b0;
               end
            end
         end else if (!bclk_rise && timed_out) begin
            locked  <= 1'b0;
            left_ok <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_i2s_audio_rx.sv
// tb/tb_i2s_audio_rx.sv - directed vector bench for i2s_audio_rx
`timescale 1ns/1ps
module tb_i2s_audio_rx;
   localparam int W = 16;

   logic         clock = 1'b0;
   logic         resetN = 1'b0;
   logic         bclk = 1'b0;
   logic         lrclk = 1'b0;
   logic         sdata = 1'b0;
   logic [W-1:0] s_l, s_r;
   logic         s_v, lck, ferr;

   i2s_audio_rx #(.SAMPLE_WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut (
      .clock(clock), .resetN(resetN), .i2sBclk(bclk), .i2sLrclk(lrclk), .i2sData(sdata),
      .sampleLeft(s_l), .sampleRight(s_r), .sampleValid(s_v), .locked(lck), .frameError(ferr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] l;
      logic [W-1:0] r;
      int           slot;
      logic [W-1:0] exp_l;
      logic [W-1:0] exp_r;
   } vec_t;

   int   n_vec = 0;
   int   n_err = 0;
   int   valid_total = 0;
   int   long_pulses = 0;
   logic prev_v = 1'b0;
   logic pending = 1'b0;
   time  last_rise = 0;

   always @(negedge clock) begin
      if (s_v) begin
         valid_total++;
         if (prev_v) long_pulses++;
      end
      prev_v = s_v;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic lr, input logic d);
      bclk = 1'b0; lrclk = lr; sdata = d;
      #40;
      bclk = 1'b1; last_rise = $time;
      #40;
   endtask

   // One-bit delay: each slot opens with the last bit of the previous slot
   task automatic send_slot(input logic lr, input logic [W-1:0] word, input int slot_bits);
      logic [63:0] bits;
      bits = '0;
      bits[63 -: W] = word;
      for (int j = 0; j < slot_bits; j++) begin
         if (j == 0) send_bit(lr, pending);
         else        send_bit(lr, bits[63-(j-1)]);
      end
      pending = bits[63-(slot_bits-1)];
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int slot);
      send_slot(1'b0, l, slot);
      send_slot(1'b1, r, slot);
   endtask

   task automatic flush();
      send_bit(1'b0, pending);
      repeat (4) @(negedge clock);
   endtask

   task automatic do_reset();
      resetN = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; pending = 1'b0;
      repeat (3) @(posedge clock);
      #3 resetN = 1'b1;
      repeat (2) @(posedge clock);
   endtask

   // Stream starting mid right slot; only the following whole L/R pair may be reported
   task automatic mid_slot_start(input logic [W-1:0] l, input logic [W-1:0] r, input string tag);
      int base;
      base = valid_total;
      send_slot(1'b1, 16'hBEEF, 20);
      send_frame(l, r, 32);
      repeat (4) @(negedge clock);
      check({tag, "_no_early_valid"}, valid_total - base, 0);
      check({tag, "_not_locked_yet"}, lck, 1'b0);
      flush();
      check({tag, "_valid_count"}, valid_total - base, 1);
      check({tag, "_left"}, s_l, l);
      check({tag, "_right"}, s_r, r);
      check({tag, "_locked"}, lck, 1'b1);
      check({tag, "_frame_error"}, ferr, 1'b0);
   endtask

   initial begin
      vec_t vecs[5];
      int   base;
      int   elapsed;
      vecs[0] = '{16'hA55A, 16'h1234, 32, 16'hA55A, 16'h1234};
      vecs[1] = '{16'h8001, 16'h7FFE, 16, 16'h8001, 16'h7FFE};
      vecs[2] = '{16'hFFFF, 16'h0000, 32, 16'hFFFF, 16'h0000};
      vecs[3] = '{16'h0001, 16'h8000, 16, 16'h0001, 16'h8000};
      vecs[4] = '{16'hC3C3, 16'h3C3C, 24, 16'hC3C3, 16'h3C3C};

      repeat (3) @(negedge clock);
      check("rst_left", s_l, 0);
      check("rst_right", s_r, 0);
      check("rst_valid", s_v, 1'b0);
      check("rst_locked", lck, 1'b0);
      check("rst_frame_error", ferr, 1'b0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         base = valid_total;
         send_frame(~vecs[i].l, ~vecs[i].r, vecs[i].slot);
         send_frame(vecs[i].l, vecs[i].r, vecs[i].slot);
         flush();
         check($sformatf("vec%0d_valid_count", i), valid_total - base, 1);
         check($sformatf("vec%0d_left", i), s_l, vecs[i].exp_l);
         check($sformatf("vec%0d_right", i), s_r, vecs[i].exp_r);
         check($sformatf("vec%0d_locked", i), lck, 1'b1);
         check($sformatf("vec%0d_frame_error", i), ferr, 1'b0);
      end

      do_reset();
      mid_slot_start(16'h0F0F, 16'hF0F0, "mid");

      do_reset();
      base = valid_total;
      send_frame(16'h1111, 16'h2222, 32);
      send_slot(1'b0, 16'h3333, 32);
      send_slot(1'b1, 16'h4444, 10);
      send_slot(1'b0, 16'h5555, 32);
      repeat (4) @(negedge clock);
      check("short_frame_error", ferr, 1'b1);
      check("short_no_valid", valid_total - base, 0);
      send_slot(1'b1, 16'h6666, 32);
      flush();
      check("short_next_valid", valid_total - base, 1);
      check("short_next_left", s_l, 16'h5555);
      check("short_next_right", s_r, 16'h6666);
      check("short_error_sticky", ferr, 1'b1);
      check("short_locked", lck, 1'b1);

      base = valid_total;
      for (int c = 0; c < 1300 && lck; c++) @(negedge clock);
      elapsed = int'(($time - last_rise) / 10);
      check("timeout_locked_low", lck, 1'b0);
      check("timeout_fall_cycle", (elapsed >= 1020 && elapsed <= 1032), 1'b1);
      if (!(elapsed >= 1020 && elapsed <= 1032))
         $display("FAIL timeout_cycles: got %0d expected about 1024", elapsed);
      check("timeout_left_hold", s_l, 16'h5555);
      check("timeout_right_hold", s_r, 16'h6666);
      check("timeout_no_valid", valid_total - base, 0);
      send_frame(16'hEEEE, 16'hDDDD, 32);
      send_frame(16'h1357, 16'h2468, 32);
      repeat (4) @(negedge clock);
      check("relock_not_before_pair", lck, 1'b0);
      flush();
      check("relock_locked", lck, 1'b1);
      check("relock_valid", valid_total - base, 1);
      check("relock_left", s_l, 16'h1357);
      check("relock_right", s_r, 16'h2468);

      for (int j = 0; j < 5; j++) send_bit(1'b0, j[0]);
      @(posedge clock);
      #3 resetN = 1'b0;
      #1;
      check("async_rst_left", s_l, 0);
      check("async_rst_right", s_r, 0);
      check("async_rst_valid", s_v, 1'b0);
      check("async_rst_locked", lck, 1'b0);
      check("async_rst_frame_error", ferr, 1'b0);
      bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; pending = 1'b0;
      repeat (3) @(posedge clock);
      #3 resetN = 1'b1;
      repeat (2) @(posedge clock);
      mid_slot_start(16'h6C6C, 16'h9393, "after_rst");

      check("valid_one_cycle", long_pulses, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/i2s_audio_rx.md
Name: i2s_audio_rx

Overview:
- I2S receiver for the audio path: the receive end of the audio clock and serial data that the Rise top forwards out on a GPIO.
- Oversamples external BCLK/LRCLK/SDATA in the `clock` domain.
- Deserialises left/right words and presents each stereo pair with a one-cycle valid strobe.
- Used for loopback checks of the test-pattern audio output and as the input stage for future audio capture cores.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel word captured (MSB-first); legal range 8..32.
- SYNC_STAGES, 2, flip-flop stages on each async input; minimum 2.
- TIMEOUT_CYCLES, 1024, `clock` cycles without a BCLK rising edge before lock is dropped; minimum 16.

Ports:
- clock  in  1  system clock; fclock >= 4 x fbclk.
- resetN  in  1  asynchronous, active-low reset.
- i2sBclk  in  1  external bit clock, asynchronous.
- i2sLrclk  in  1  word select, asynchronous; 0 = left, 1 = right.
- i2sData  in  1  serial data, asynchronous.
- sampleLeft  out  SAMPLE_WIDTH  last complete left word.
- sampleRight  out  SAMPLE_WIDTH  last complete right word.
- sampleValid  out  1  one-cycle strobe; a new L/R pair is on the sample outputs.
- locked  out  1  high while frames are being received.
- frameError  out  1  sticky; a short slot was seen. Cleared only by reset.

Behaviour:
- **Reset (resetN low, asynchronous):**
  - All sync flops, shift register, bit counter and timeout counter clear to 0.
  - State = WAIT_SYNC.
  - Outputs: sampleLeft = 0, sampleRight = 0, sampleValid = 0, locked = 0, frameError = 0.
- **Input synchronisation:**
  - Each input passes through SYNC_STAGES flops, plus one history flop on BCLK.
  - bclkRise = synced BCLK high AND history low.
  - LRCLK and SDATA are taken from their synced outputs at the bclkRise cycle. Equal stage counts keep the three inputs aligned.
- **Per-edge sampling:**
  - At each bclkRise, sample lr and d.
  - lrChange = lr != lrPrev; then lrPrev <= lr.
- **WAIT_SYNC:**
  - Shift register idle; no outputs update.
  - On the first bclkRise with lrChange:
    - bitCount <= 0
    - channel <= lr
    - leftOk <= 0
    - go to RUN.
- **RUN, bclkRise without lrChange:**
  - If bitCount < SAMPLE_WIDTH: shift d into the LSB and increment bitCount.
  - Otherwise ignore (slot padding). bitCount saturates at SAMPLE_WIDTH.
- **RUN, bclkRise with lrChange (I2S one-bit delay):**
  - d belongs to the old slot. Shift it in if bitCount < SAMPLE_WIDTH, then evaluate the word.
  - Completed bitCount == SAMPLE_WIDTH:
    - Old channel left: write sampleLeft, leftOk <= 1.
    - Old channel right and leftOk = 1: write sampleRight, pulse sampleValid, leftOk <= 0.
    - Old channel right and leftOk = 0: discard.
  - Completed bitCount < SAMPLE_WIDTH: frameError <= 1, leftOk <= 0, word discarded.
  - In all cases: bitCount <= 0, channel <= lr.
- **Latency and output timing:**
  - sampleLeft, sampleRight and sampleValid update on the clock edge after the bclkRise cycle, i.e. 1 registered cycle after detection.
  - sampleValid is high for exactly one clock.
  - sampleLeft/sampleRight hold until the next accepted word.
- **locked:**
  - Set 1 on the first complete valid pair.
  - Cleared on timeout.
- **Timeout:**
  - The counter resets on every bclkRise and increments otherwise, saturating.
  - On reaching TIMEOUT_CYCLES: locked <= 0, state <= WAIT_SYNC, leftOk <= 0.
  - sample outputs retain their last values.
- **Reset mid-frame:** the partial word is lost; resync requires a fresh LRCLK transition.
- **Slot longer than SAMPLE_WIDTH** (e.g. 32-bit slots with W = 16): the top W bits are kept and the remainder ignored. This is not an error.

Test Plan:
1. W=16, BCLK = clock/8, 32-bit slots, L=0xA55A, R=0x1234 → after the first full pair: one sampleValid pulse, sampleLeft=0xA55A, sampleRight=0x1234, locked=1, frameError=0.
2. Start stimulus mid right slot → no sampleValid until the first whole L then R pair; the first pulse carries the values of that pair only.
3. W=16 with 16-bit slots (LSB on the LRCLK-change edge), L=0x8001, R=0x7FFE → outputs exactly 0x8001/0x7FFE, confirming the one-bit-delay handling.
4. Right slot truncated to 10 bits → frameError=1 and stays set; no sampleValid for that frame; the next good frame still produces valid output.
5. Stop BCLK for 1100 clocks → locked falls at cycle 1024 after the last edge and outputs hold; on restart, relock after the first complete pair.
6. Assert resetN low mid-word (async, between clock edges) → all outputs 0 immediately; after release, behaviour matches scenario 2.
